// File: rtl/uart_rx.sv
// UART receiver. It assembles p_data_buffer bytes into one word with the first byte in the MSB,
// and publishes the word on op_data with a one-cycle o_dv pulse.
module uart_rx #(
  parameter int p_preescaler  = 8,
  parameter int p_data_buffer = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_rx,
  output logic [8*p_data_buffer-1:0] op_data,
  output logic                       o_dv,
  output logic                       o_frame_err,
  output logic                       o_busy
);

  localparam int CW = $clog2(p_preescaler);
  localparam int BW = (p_data_buffer > 1) ? $clog2(p_data_buffer) : 1;
  localparam logic [CW-1:0] HALF = CW'(p_preescaler / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(p_preescaler - 1);
  localparam logic [BW-1:0] LAST = BW'(p_data_buffer - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                     state_q;
  logic [CW-1:0]              cnt_q;
  logic [2:0]                 idx_q;
  logic [7:0]                 byte_q;
  logic [BW-1:0]              byte_cnt_q;
  logic [8*p_data_buffer-1:0] buf_q;
  logic [8*p_data_buffer-1:0] op_data_q;
  logic [8*p_data_buffer-1:0] word_d;
  logic                       dv_q;
  logic                       ferr_q;
  logic                       meta_q;
  logic                       line_q;

  // The partial word with the byte that has just completed placed in its slot.
  always_comb begin
    word_d = buf_q;
    for (int k = 0; k < p_data_buffer; k++) begin
      if (byte_cnt_q == BW'(k)) word_d[8*(p_data_buffer-k)-1 -: 8] = byte_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      op_data_q  <= '0;
      dv_q       <= 1'b0;
      ferr_q     <= 1'b0;
      meta_q     <= 1'b1;
      line_q     <= 1'b1;
    end else begin
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
      meta_q <= i_rx;
      line_q <= meta_q;
      case (state_q)
        IDLE: begin
          if (!line_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          // Recheck the line at mid start bit so that short glitches are ignored.
          if (cnt_q == HALF) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= line_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == FULL) begin
            cnt_q         <= '0;
            byte_q[idx_q] <= line_q;
            idx_q         <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == FULL) begin
            cnt_q <= '0;
            if (line_q) begin
              state_q <= IDLE;
              buf_q   <= word_d;
              if (byte_cnt_q == LAST) begin
                op_data_q  <= word_d;
                dv_q       <= 1'b1;
                byte_cnt_q <= '0;
              end else begin
                byte_cnt_q <= byte_cnt_q + BW'(1);
              end
            end else begin
              state_q    <= WAIT_HIGH;
              ferr_q     <= 1'b1;
              byte_cnt_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_HIGH: begin
          if (line_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_data     = op_data_q;
  assign o_dv        = dv_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (8 clk/bit, 2-byte words). It runs directed scenarios and then random traffic,
// and checks the results against a byte-queue reference model.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rx = 1'b1;
  logic [15:0] op_data;
  logic        o_dv;
  logic        o_frame_err;
  logic        o_busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]  partial[$];
  logic [15:0] expWords[$];
  logic [15:0] lastWord = 16'h0;
  int          expDv = 0;
  int          expFerr = 0;
  int          dvSeen = 0;
  int          ferrSeen = 0;

  uart_rx #(.p_preescaler(8), .p_data_buffer(2)) dut (
    .clk(clk), .rst(rst), .i_rx(i_rx), .op_data(op_data),
    .o_dv(o_dv), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The model is updated at the start of the frame, so the expected word is already queued when o_dv arrives.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    logic [15:0] w;
    if (stopBit) begin
      partial.push_back(b);
      if (partial.size() == 2) begin
        w = {partial[0], partial[1]};
        expWords.push_back(w);
        lastWord = w;
        expDv++;
        partial.delete();
      end
    end else begin
      partial.delete();
      expFerr++;
    end
    i_rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (8) @(negedge clk);
    end
    i_rx = stopBit;
    repeat (8) @(negedge clk);
    i_rx = 1'b1;
  endtask

  task automatic idleBits(input int n);
    i_rx = 1'b1;
    repeat (8 * n) @(negedge clk);
  endtask

  task automatic glitch();
    i_rx = 1'b0;
    repeat (2) @(negedge clk);
    i_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    partial.delete();
    lastWord = 16'h0;
  endtask

  task automatic checkScenario(input string tag);
    idleBits(3);
    checkOutput({tag, "_dv_count"}, dvSeen, expDv);
    checkOutput({tag, "_ferr_count"}, ferrSeen, expFerr);
    checkOutput({tag, "_op_data"}, op_data, lastWord);
    checkOutput({tag, "_busy_idle"}, o_busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_dv || o_frame_err) checkOutput("dv_ferr_exclusive", o_dv && o_frame_err, 1'b0);
      if (o_dv) begin
        dvSeen++;
        if (expWords.size() == 0) checkOutput("dv_unexpected", 1'b1, 1'b0);
        else checkOutput("dv_word", op_data, expWords.pop_front());
      end
      if (o_frame_err) ferrSeen++;
    end
  end

  initial begin
    logic [7:0] b;
    logic       good;
    repeat (3) @(negedge clk);
    checkOutput("reset_op_data", op_data, 16'h0);
    checkOutput("reset_dv", o_dv, 1'b0);
    checkOutput("reset_ferr", o_frame_err, 1'b0);
    checkOutput("reset_busy", o_busy, 1'b0);
    rst = 1'b0;
    idleBits(1);

    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    checkScenario("two_frames");

    glitch();
    checkScenario("glitch");

    applyStimulus(8'h55, 1'b0);
    idleBits(1);
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h34, 1'b1);
    checkScenario("frame_err");

    applyStimulus(8'hFF, 1'b1);
    idleBits(1);
    pulseReset();
    checkOutput("midword_reset_op_data", op_data, 16'h0);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b1);
    checkScenario("midword_reset");

    applyStimulus(8'hDE, 1'b1);
    applyStimulus(8'hAD, 1'b1);
    applyStimulus(8'hBE, 1'b1);
    applyStimulus(8'hEF, 1'b1);
    checkScenario("back_to_back");

    // Random traffic: random bytes, some frames with a bad stop bit, random gaps and glitches.
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      good = ($urandom_range(5) != 0);
      applyStimulus(b, good);
      if (!good) idleBits(1 + $urandom_range(1));
      else idleBits($urandom_range(2));
      if ($urandom_range(9) == 0) begin
        idleBits(1);
        glitch();
      end
    end
    checkScenario("random");
    checkOutput("pending_words", expWords.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
